cache_fill_fsm: RTL

Miss-handling controller for the direct-mapped caches of the pipelined 16-bit CPU. On a miss it latches the block base address, issues one memory read per 2-byte word of the 16-byte block, counts returning words and steers them into the data array, then writes the tag. Sits between the cache tag-compare logic (upstream, raises the miss) and the multi-cycle main memory and cache arrays (downstream). Its state is a 2-bit register with write enable.

---
 rtl/cache_fill_fsm_if.sv | 53 +++++
 rtl/cache_fill_fsm.sv | 88 ++++++++
 2 files changed

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if
//   Bundles the miss handshake, the memory read/return signals and the
//   cache array write strobes used by the block-fill controller.
//   master : upstream/downstream side (drives miss and memory returns)
//   slave  : the fill controller itself
//   Signals:
//     miss_detected     miss on the current access
//     miss_address      byte address of the missing access
//     memory_data_valid one returned memory word this cycle
//     fsm_busy          fill in progress (pipeline stall)
//     mem_read          memory read request this cycle
//     memory_address    byte address of the requested word
//     write_data_array  write the returned word into the data array
//     word_index        word slot within the block for that write
//     write_tag_array   write tag and valid bit for the filled block
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic              write_tag_array;

  modport master (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    input  fsm_busy,
    input  mem_read,
    input  memory_address,
    input  write_data_array,
    input  word_index,
    input  write_tag_array
  );

  modport slave (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    output fsm_busy,
    output mem_read,
    output memory_address,
    output write_data_array,
    output word_index,
    output write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss handler for a direct-mapped cache with 2-byte words. On a miss it
//   latches the block base, issues one memory read per word of the block,
//   counts returning words and steers each into its data-array slot, and
//   writes the tag together with the last word.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  cache_fill_fsm_if.slave (miss inputs, memory returns, strobes)
//   Outputs are decoded from registered state; the data/tag write strobes
//   additionally follow memory_data_valid in the same cycle. Nothing depends
//   combinationally on miss_detected or miss_address.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.slave bus
);

  localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = IDX_W + 1;          // word index plus byte-in-word bit
  localparam int CNT_W  = IDX_W + 1;          // issue count must reach WORDS_PER_BLOCK
  localparam int BASE_W = ADDR_W - OFF_W;

  localparam logic [CNT_W-1:0] ISSUE_DONE = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01
  } state_t;

  state_t            state_reg;
  logic [BASE_W-1:0] base_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [IDX_W-1:0]  rcv_cnt_reg;

  logic in_fill;
  logic issuing;
  logic word_take;

  assign in_fill   = (state_reg == FILL);
  assign issuing   = in_fill && (issue_cnt_reg != ISSUE_DONE);
  assign word_take = in_fill && bus.memory_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.miss_detected) begin
            base_reg      <= bus.miss_address[ADDR_W-1:OFF_W];
            issue_cnt_reg <= '0;
            rcv_cnt_reg   <= '0;
            state_reg     <= FILL;
          end
        end
        FILL: begin
          // Issue side runs freely and parks at WORDS_PER_BLOCK.
          if (issuing)
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
          // Receive side advances only on valid pulses, so return gaps are fine.
          if (bus.memory_data_valid) begin
            rcv_cnt_reg <= rcv_cnt_reg + 1'b1;
            if (rcv_cnt_reg == LAST_IDX)
              state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;  // unused encodings recover to IDLE
      endcase
    end
  end

  assign bus.fsm_busy         = in_fill;
  assign bus.mem_read         = issuing;
  // Once issuing is done, issue_cnt_reg[IDX_W-1:0] wraps to 0, giving the base.
  assign bus.memory_address   = in_fill ? {base_reg, issue_cnt_reg[IDX_W-1:0], 1'b0} : '0;
  assign bus.write_data_array = word_take;
  assign bus.word_index       = word_take ? rcv_cnt_reg : '0;
  assign bus.write_tag_array  = word_take && (rcv_cnt_reg == LAST_IDX);

endmodule
